seg4x7_scroll_ctrl: RTL and testbench

//  Text scroller feeding the 32-bit ASCII word of the 4-digit 7-segment driver.
//  A host streams a message in, one char per handshake. The block then scrolls it

---
 rtl/seg4x7_scroll_ctrl.sv | 135 +++++++++++++
 tb/tb_seg4x7_scroll_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seg4x7_scroll_ctrl.sv
// Message scroller for the 4-digit 7-segment ASCII driver: buffers a host-streamed
// string and slides it right-to-left across the digits, looping until cleared.
module seg4x7_scroll_ctrl #(
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int STEP_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_char,
    input  logic        wr_last,
    input  logic        clear,
    output logic [31:0] disp_word,
    output logic        busy,
    output logic        wrap
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int IDX_W = ADDR_W + 3;
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [31:0] BLANK = 32'h2020_2020;

    typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   pos_q, pos_d;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic [31:0]        disp_word_q, disp_word_d;
    logic               wr_ready_q, wr_ready_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic [7:0]         mem_q [DEPTH];

    logic               accept, step, mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [IDX_W-1:0]   idx;

    assign accept = wr_valid & wr_ready_q;
    assign step   = (state_q == SCROLL) && (step_cnt_q == CNT_W'(STEP_DIV - 1));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pos_d       = pos_q;
        step_cnt_d  = step_cnt_q;
        wrap_d      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        disp_word_d = BLANK;
        idx         = '0;

        if (clear) begin
            state_d    = IDLE;
            len_d      = '0;
            pos_d      = '0;
            step_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    mem_we     = 1'b1;
                    len_d      = LEN_W'(1);
                    pos_d      = '0;
                    step_cnt_d = '0;
                    state_d    = wr_last ? SCROLL : LOAD;
                end
                LOAD: if (accept) begin
                    mem_we   = 1'b1;
                    mem_addr = len_q[ADDR_W-1:0];
                    len_d    = len_q + LEN_W'(1);
                    // A full buffer forces the end of the message.
                    if (wr_last || (len_q + LEN_W'(1) == LEN_W'(DEPTH))) begin
                        state_d    = SCROLL;
                        pos_d      = '0;
                        step_cnt_d = '0;
                    end
                end
                SCROLL: begin
                    step_cnt_d = step ? '0 : step_cnt_q + CNT_W'(1);
                    if (step) begin
                        if (pos_q == len_q + LEN_W'(3)) begin
                            pos_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            pos_d = pos_q + LEN_W'(1);
                        end
                    end
                    // Window over V = 4 blanks, then the message; out of range reads blank.
                    for (int k = 0; k < 4; k++) begin
                        idx = IDX_W'(pos_q) + IDX_W'(k);
                        if (idx >= IDX_W'(4) && idx < IDX_W'(len_q) + IDX_W'(4))
                            disp_word_d[8*(3-k) +: 8] = mem_q[ADDR_W'(idx - IDX_W'(4))];
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        wr_ready_d = (state_d != SCROLL);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            pos_q       <= '0;
            step_cnt_q  <= '0;
            disp_word_q <= BLANK;
            wr_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pos_q       <= pos_d;
            step_cnt_q  <= step_cnt_d;
            disp_word_q <= disp_word_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
            wrap_q      <= wrap_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_addr] <= wr_char;
    end

    assign wr_ready  = wr_ready_q;
    assign disp_word = disp_word_q;
    assign busy      = busy_q;
    assign wrap      = wrap_q;
endmodule

// File: tb/tb_seg4x7_scroll_ctrl.sv
// Scoreboard bench for seg4x7_scroll_ctrl: expected windows are queued by the
// stimulus, a negedge monitor pops one per disp_word change while busy.
module tb_seg4x7_scroll_ctrl;
    localparam int DEPTH = 8, ADDR_W = 3, STEP_DIV = 4;
    localparam logic [31:0] BLANK = 32'h2020_2020;

    logic        clk = 1'b0, reset_n = 1'b1;
    logic        wr_valid = 1'b0, wr_last = 1'b0, clear = 1'b0;
    logic [7:0]  wr_char = 8'h00;
    logic        wr_ready, busy, wrap;
    logic [31:0] disp_word;

    seg4x7_scroll_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STEP_DIV(STEP_DIV)) dut (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_char(wr_char), .wr_last(wr_last), .clear(clear),
        .disp_word(disp_word), .busy(busy), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] word; logic wrp; } exp_t;
    exp_t q[$];

    int total = 0, bad = 0, cyc = 0;
    bit mon_en = 1'b1;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic wr);
        exp_t e;
        e.word = w;
        e.wrp  = wr;
        q.push_back(e);
    endtask

    // Monitor: one pop per visible window change during a scroll.
    logic [31:0] prev_w = BLANK;
    bit have_prev = 0, wrap_pend = 0;
    int last_chg = 0;
    always @(negedge clk) begin
        if (!reset_n || !busy) begin
            prev_w = BLANK; have_prev = 0; wrap_pend = 0;
        end else begin
            if (disp_word !== prev_w && mon_en) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_window: got %h want no change", disp_word);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("window", disp_word, e.word);
                    chk("wrap_before_window", 32'(wrap_pend), 32'(e.wrp));
                    if (have_prev) chk("step_interval", 32'(cyc - last_chg), 32'(STEP_DIV));
                end
                prev_w = disp_word; last_chg = cyc; have_prev = 1; wrap_pend = 0;
            end
            if (wrap) wrap_pend = 1;
        end
    end

    task automatic send(input logic [7:0] c, input logic last, input logic exp_rdy, input string nm);
        wr_valid = 1'b1; wr_char = c; wr_last = last;
        chk(nm, 32'(wr_ready), 32'(exp_rdy));
        @(posedge clk); #1;
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 400 && q.size() != 0; c++) @(posedge clk);
        #1 chk(nm, 32'(q.size()), 32'd0);
    endtask

    task automatic do_clear(input string nm);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_ready"}, 32'(wr_ready), 32'd1);
        chk({nm, "_disp"}, disp_word, BLANK);
        chk({nm, "_wrap"}, 32'(wrap), 32'd0);
    endtask

    function automatic logic [31:0] win8(input int p);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = p + k;
            w[8*(3-k) +: 8] = (i >= 4 && i < 12) ? 8'(8'h41 + i - 4) : 8'h20;
        end
        return w;
    endfunction

    initial begin
        bit found;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_disp", disp_word, BLANK);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("hold_disp", disp_word, BLANK);
        chk("hold_busy", 32'(busy), 32'd0);

        // "HI": two full loops.
        send(8'h48, 1'b0, 1'b1, "hi_rdy0");
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_disp", disp_word, BLANK);
        for (int l = 0; l < 2; l++) begin
            push(32'h20202048, 0); push(32'h20204849, 0); push(32'h20484920, 0);
            push(32'h48492020, 0); push(32'h49202020, 0); push(32'h20202020, 1);
        end
        send(8'h49, 1'b1, 1'b1, "hi_rdy1");
        chk("scroll_ready", 32'(wr_ready), 32'd0);
        drain("hi_drain");
        do_clear("hi_clr");

        // Ten chars, no wr_last: only the first eight land; wr_valid held during scroll.
        for (int i = 0; i < 10; i++) begin
            if (i == 8)
                for (int p = 1; p <= 12; p++) push(win8(p % 12), p == 12);
            send(8'(8'h41 + i), 1'b0, i < 8, "full_rdy");
        end
        wr_valid = 1'b1; wr_char = 8'h5A;
        drain("full_drain");
        wr_valid = 1'b0;
        do_clear("full_clr");

        // Single "A" straight to scroll, then clear coinciding with a step.
        push(32'h20202041, 0); push(32'h20204120, 0); push(32'h20412020, 0);
        push(32'h41202020, 0); push(32'h20202020, 1);
        send(8'h41, 1'b1, 1'b1, "a_rdy");
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (wrap) found = 1;
        end
        chk("a_wrap_seen", 32'(found), 32'd1);
        repeat (3) @(posedge clk);
        #1 do_clear("step_clr");
        chk("a_queue", 32'(q.size()), 32'd0);

        // Async reset mid-scroll.
        mon_en = 1'b0;
        send(8'h48, 1'b0, 1'b1, "rs_rdy0");
        send(8'h49, 1'b1, 1'b1, "rs_rdy1");
        repeat (10) @(posedge clk);
        #2;
        chk("pre_rst_disp", disp_word, 32'h20204849);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_disp", disp_word, BLANK);
        chk("mid_rst_ready", 32'(wr_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_wrap", 32'(wrap), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
